// File: rtl/camera_od_pad_ctrl.sv
// camera_od_pad_ctrl: open-drain pad controller with input sync, glitch filter and stuck-low detection
module camera_od_pad_ctrl #(
  parameter int NUM_CH         = 2,
  parameter int PAD_CONF_WIDTH = 10,
  parameter int FILT_W         = 4,
  parameter int STUCK_W        = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_CH-1:0]                  ch_out_i,
  input  logic [NUM_CH-1:0]                  ch_oen_i,
  output logic [NUM_CH-1:0]                  ch_in_o,
  output logic [NUM_CH-1:0]                  pad_o,
  input  logic [NUM_CH-1:0]                  pad_i,
  output logic [NUM_CH*PAD_CONF_WIDTH-1:0]   pad_cfg_o,
  input  logic [PAD_CONF_WIDTH-1:0]          base_cfg_i,
  input  logic [FILT_W-1:0]                  filt_len_i,
  input  logic [STUCK_W-1:0]                 stuck_thr_i,
  input  logic                               stuck_clr_i,
  output logic [NUM_CH-1:0]                  stuck_o,
  input  logic                               loopback_en_i
);
  localparam logic [PAD_CONF_WIDTH-1:0] CFG_SET = PAD_CONF_WIDTH'(10'h3A0);
  localparam logic [STUCK_W-1:0] SC_MAX = '1;
  logic [NUM_CH-1:0] oen_q, oen_d, pad_q, pad_d, s1_q, s1_d, s2_q, s2_d, in_q, in_d, stuck_q, stuck_d;
  logic [NUM_CH-1:0] line, sel, sc_clr;
  logic [NUM_CH*PAD_CONF_WIDTH-1:0] cfg_q, cfg_d;
  logic [FILT_W-1:0] cnt_q [NUM_CH];
  logic [FILT_W-1:0] cnt_d [NUM_CH];
  logic [STUCK_W-1:0] sc_q [NUM_CH];
  logic [STUCK_W-1:0] sc_d [NUM_CH];
  assign line      = oen_q | pad_q;
  assign sel       = loopback_en_i ? line : pad_i;
  assign pad_o     = pad_q;
  assign pad_cfg_o = cfg_q;
  assign ch_in_o   = in_q;
  assign stuck_o   = stuck_q;
  // next-state: output registers, synchroniser, glitch filter and stuck-low counters per channel
  always_comb begin
    oen_d = ch_oen_i;
    pad_d = ch_out_i;
    s1_d  = sel;
    s2_d  = s1_q;
    cfg_d = {NUM_CH{base_cfg_i | CFG_SET}};
    in_d  = in_q;
    stuck_d = stuck_q;
    sc_clr  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_d[k*PAD_CONF_WIDTH+5] = ch_oen_i[k];
      cfg_d[k*PAD_CONF_WIDTH+9] = ch_oen_i[k];
      in_d[k]  = (s2_q[k] != in_q[k] && cnt_q[k] >= filt_len_i) ? s2_q[k] : in_q[k];
      cnt_d[k] = (s2_q[k] == in_q[k] || cnt_q[k] >= filt_len_i) ? '0 : cnt_q[k] + FILT_W'(1);
      sc_clr[k] = stuck_clr_i || stuck_thr_i == '0 || !oen_q[k] || in_q[k];
      sc_d[k]  = sc_clr[k] ? '0 : (sc_q[k] == SC_MAX ? sc_q[k] : sc_q[k] + STUCK_W'(1));
      stuck_d[k] = !stuck_clr_i && (stuck_q[k] || (!sc_clr[k] && sc_q[k] == stuck_thr_i - STUCK_W'(1)));
    end
  end
  // state registers; reset releases every pad and idles the input path high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oen_q   <= '1;
      pad_q   <= '1;
      s1_q    <= '1;
      s2_q    <= '1;
      in_q    <= '1;
      stuck_q <= '0;
      cfg_q   <= {NUM_CH{base_cfg_i | CFG_SET}};
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        sc_q[k]  <= '0;
      end
    end else begin
      oen_q   <= oen_d;
      pad_q   <= pad_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      in_q    <= in_d;
      stuck_q <= stuck_d;
      cfg_q   <= cfg_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
        sc_q[k]  <= sc_d[k];
      end
    end
  end
endmodule

// File: tb/tb_camera_od_pad_ctrl.sv
// tb_camera_od_pad_ctrl: directed self-checking bench for camera_od_pad_ctrl
module tb_camera_od_pad_ctrl;
  logic        clk = 0;
  logic        rst;
  logic [1:0]  ch_out, ch_oen, ch_in, pad_o, pad_i, stuck;
  logic [19:0] pad_cfg;
  logic [9:0]  base_cfg;
  logic [3:0]  filt_len;
  logic [15:0] stuck_thr;
  logic        stuck_clr, loopback;
  int n_chk = 0;
  int n_fail = 0;
  camera_od_pad_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ch_out_i(ch_out), .ch_oen_i(ch_oen), .ch_in_o(ch_in),
    .pad_o(pad_o), .pad_i(pad_i), .pad_cfg_o(pad_cfg), .base_cfg_i(base_cfg),
    .filt_len_i(filt_len), .stuck_thr_i(stuck_thr), .stuck_clr_i(stuck_clr),
    .stuck_o(stuck), .loopback_en_i(loopback)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    base_cfg  = 10'h015;
    rst       = 1;
    ch_out    = 2'($urandom);
    ch_oen    = 2'($urandom);
    pad_i     = 2'($urandom);
    filt_len  = 4'($urandom);
    stuck_thr = 16'($urandom);
    stuck_clr = 1'($urandom);
    loopback  = 1'($urandom);
    step(3);
    chk("rst_pad_o", 32'(pad_o), 32'h3);
    chk("rst_cfg", 32'(pad_cfg), 32'({10'h3B5, 10'h3B5}));
    chk("rst_ch_in", 32'(ch_in), 32'h3);
    chk("rst_stuck", 32'(stuck), 32'h0);
    ch_out = 2'b11; ch_oen = 2'b11; pad_i = 2'b11;
    filt_len = 0; stuck_thr = 0; stuck_clr = 0; loopback = 0;
    rst = 0;
    step(4);
    chk("idle_ch_in", 32'(ch_in), 32'h3);
    ch_oen = 2'b10; ch_out = 2'b10;
    step(1);
    chk("drv_pad_o", 32'(pad_o), 32'h2);
    chk("drv_cfg", 32'(pad_cfg), 32'({10'h3B5, 10'h195}));
    ch_oen = 2'b11; ch_out = 2'b11;
    step(1);
    chk("rel_cfg", 32'(pad_cfg), 32'({10'h3B5, 10'h3B5}));
    filt_len = 3;
    pad_i[1] = 0;
    step(3);
    pad_i[1] = 1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_rej", 32'(ch_in), 32'h3);
    end
    pad_i[1] = 0;
    step(5);
    chk("filt_before", 32'(ch_in), 32'h3);
    step(1);
    chk("filt_fall", 32'(ch_in), 32'h1);
    pad_i[1] = 1;
    step(8);
    chk("filt_rise", 32'(ch_in), 32'h3);
    filt_len = 0; loopback = 1;
    ch_oen = 2'b10; ch_out = 2'b10;
    step(3);
    chk("lb_before", 32'(ch_in), 32'h3);
    step(1);
    chk("lb_fall", 32'(ch_in), 32'h2);
    ch_oen = 2'b11; ch_out = 2'b11; loopback = 0;
    step(6);
    chk("lb_rel", 32'(ch_in), 32'h3);
    stuck_thr = 20;
    pad_i = 2'b10;
    step(22);
    chk("stuck_before", 32'(stuck), 32'h0);
    step(1);
    chk("stuck_set", 32'(stuck), 32'h1);
    step(30);
    chk("stuck_hold", 32'(stuck), 32'h1);
    stuck_clr = 1;
    step(1);
    stuck_clr = 0;
    chk("stuck_clr", 32'(stuck), 32'h0);
    step(19);
    chk("reset_before", 32'(stuck), 32'h0);
    step(1);
    chk("reset_set", 32'(stuck), 32'h1);
    stuck_clr = 1;
    step(1);
    stuck_clr = 0;
    stuck_thr = 0;
    step(40);
    chk("thr0_never", 32'(stuck), 32'h0);
    stuck_thr = 20;
    step(19);
    stuck_clr = 1;
    step(1);
    stuck_clr = 0;
    chk("clr_wins", 32'(stuck), 32'h0);
    step(5);
    chk("clr_restart", 32'(stuck), 32'h0);
    step(15);
    chk("restart_set", 32'(stuck), 32'h1);
    ch_oen = 2'b00; ch_out = 2'b00;
    step(1);
    chk("mid_drv", 32'(pad_o), 32'h0);
    rst = 1;
    step(1);
    chk("mid_rst_pad", 32'(pad_o), 32'h3);
    chk("mid_rst_cfg", 32'(pad_cfg), 32'({10'h3B5, 10'h3B5}));
    chk("mid_rst_stuck", 32'(stuck), 32'h0);
    chk("mid_rst_in", 32'(ch_in), 32'h3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
